// File: rtl/stm_audio_tx_if.sv
// ---------------------------------------------------------------------------
// stm_audio_tx_if
//
// Purpose: the parallel audio link from the FPGA to the STM32. One 16-bit
// sample is moved per 4-phase valid/ack handshake.
//
// Signals:
//   stm_audio_data   sample presented to the STM32
//   stm_audio_valid  high while stm_audio_data is stable and may be taken
//   stm_audio_ack    STM32 acknowledge, asynchronous to the FPGA clock
//
// Modports:
//   master  FPGA side (drives data/valid, receives ack)
//   slave   STM32 side (receives data/valid, drives ack)
// ---------------------------------------------------------------------------
`timescale 1ns/1ps

interface stm_audio_tx_if #(
    parameter int OUT_AUDIO_WIDTH = 16
);
    logic [OUT_AUDIO_WIDTH-1:0] stm_audio_data;
    logic                       stm_audio_valid;
    logic                       stm_audio_ack;

    modport master (
        output stm_audio_data,
        output stm_audio_valid,
        input  stm_audio_ack
    );

    modport slave (
        input  stm_audio_data,
        input  stm_audio_valid,
        output stm_audio_ack
    );
endinterface

// File: rtl/stm_audio_tx.sv
// ---------------------------------------------------------------------------
// stm_audio_tx
//
// Purpose: moves codec ADC capture samples from the Audio_Controller input
// side to the STM32. Each capture pair is popped from Audio_Controller,
// reduced to one 16-bit sample (upper bits of the selected channel), buffered
// in a small FIFO and presented on a parallel GPIO bus with a 4-phase
// valid/ack handshake.
//
// Ports:
//   clk                     system clock (CLOCK_50)
//   reset_n                 asynchronous active-low reset
//   left_channel_audio_in   left capture sample, valid while available
//   right_channel_audio_in  right capture sample
//   audio_in_available      Audio_Controller holds a capture pair
//   read_audio_in           one-cycle pop strobe to Audio_Controller
//   chan_sel                0 = left, 1 = right (quasi-static)
//   stm                     stm_audio_tx_if.master: data/valid out, ack in
//   overrun_cnt             samples dropped on a full FIFO (saturating)
//   timeout_cnt             samples abandoned on ack timeout (saturating)
//
// Optional feature:
//   STM_AUDIO_TX_MONO_MIX_EN  when defined, chan_sel is ignored and the
//                             stored sample is the mono mix (L+R)/2.
// ---------------------------------------------------------------------------
`timescale 1ns/1ps

module stm_audio_tx #(
    parameter int IN_AUDIO_WIDTH  = 32,
    parameter int OUT_AUDIO_WIDTH = 16,
    parameter int FIFO_DEPTH      = 4,
    parameter int ACK_TIMEOUT     = 4096
) (
    input  logic                      clk,
    input  logic                      reset_n,
    input  logic [IN_AUDIO_WIDTH-1:0] left_channel_audio_in,
    input  logic [IN_AUDIO_WIDTH-1:0] right_channel_audio_in,
    input  logic                      audio_in_available,
    output logic                      read_audio_in,
    input  logic                      chan_sel,
    stm_audio_tx_if.master            stm,
    output logic [7:0]                overrun_cnt,
    output logic [7:0]                timeout_cnt
);

    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam int TMO_W = $clog2(ACK_TIMEOUT + 1);

    localparam logic [CNT_W-1:0] FIFO_FULL_CNT = CNT_W'(FIFO_DEPTH);
    localparam logic [TMO_W-1:0] TMO_LAST      = TMO_W'(ACK_TIMEOUT - 1);

    typedef enum logic [1:0] {
        IDLE,
        SETUP,
        WAIT_ACK,
        WAIT_REL
    } state_t;

    // Capture strobe and ack synchroniser
    logic rd_q, rd_d;
    logic ack_meta_q, ack_meta_d;
    logic ack_s_q, ack_s_d;

    // Sample FIFO
    logic [OUT_AUDIO_WIDTH-1:0] mem_q [FIFO_DEPTH];
    logic [OUT_AUDIO_WIDTH-1:0] mem_d [FIFO_DEPTH];
    logic [PTR_W-1:0]           wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]           rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]           count_q, count_d;
    logic [7:0]                 overrun_q, overrun_d;

    logic fifo_empty;
    logic fifo_full;
    logic push;
    logic pop;

    // Handshake FSM state and its registered outputs
    state_t                     state_q;
    logic [OUT_AUDIO_WIDTH-1:0] data_q;
    logic                       valid_q;
    logic [TMO_W-1:0]           tmo_q;
    logic [7:0]                 timeout_q;

    logic [OUT_AUDIO_WIDTH-1:0] cap_sample;

    // -----------------------------------------------------------------------
    // Sample reduction: keep the top OUT_AUDIO_WIDTH bits so the sign bit
    // survives truncation.
    // -----------------------------------------------------------------------
`ifdef STM_AUDIO_TX_MONO_MIX_EN
    // One extra bit of headroom makes L+R exact; dropping the LSB of the sum
    // is the arithmetic shift right by one, so the mix can never wrap.
    logic [IN_AUDIO_WIDTH:0] mix_sum;
    logic                    unused_mix_bits;

    always_comb begin
        mix_sum = {left_channel_audio_in[IN_AUDIO_WIDTH-1], left_channel_audio_in}
                + {right_channel_audio_in[IN_AUDIO_WIDTH-1], right_channel_audio_in};
        cap_sample = mix_sum[IN_AUDIO_WIDTH -: OUT_AUDIO_WIDTH];
    end

    assign unused_mix_bits = ^{mix_sum[IN_AUDIO_WIDTH-OUT_AUDIO_WIDTH:0], chan_sel};
`else
    logic unused_low_bits;

    always_comb begin
        cap_sample = chan_sel ? right_channel_audio_in[IN_AUDIO_WIDTH-1 -: OUT_AUDIO_WIDTH]
                              : left_channel_audio_in[IN_AUDIO_WIDTH-1 -: OUT_AUDIO_WIDTH];
    end

    assign unused_low_bits = ^{left_channel_audio_in[IN_AUDIO_WIDTH-OUT_AUDIO_WIDTH-1:0],
                               right_channel_audio_in[IN_AUDIO_WIDTH-OUT_AUDIO_WIDTH-1:0]};
`endif

    // -----------------------------------------------------------------------
    // Next-state logic for the capture strobe, ack synchroniser and FIFO.
    // The strobe is never issued two cycles running so Audio_Controller has
    // a cycle to advance its show-ahead output after each pop. Captures
    // never stall: with the FIFO full and no pop in the same cycle the
    // sample is thrown away and counted.
    // -----------------------------------------------------------------------
    always_comb begin
        rd_d       = audio_in_available & ~rd_q;
        ack_meta_d = stm.stm_audio_ack;
        ack_s_d    = ack_meta_q;

        fifo_empty = (count_q == '0);
        fifo_full  = (count_q == FIFO_FULL_CNT);
        pop        = (state_q == IDLE) && !fifo_empty && !ack_s_q;
        push       = rd_q && (!fifo_full || pop);

        mem_d     = mem_q;
        wr_ptr_d  = wr_ptr_q;
        rd_ptr_d  = rd_ptr_q;
        count_d   = count_q;
        overrun_d = overrun_q;

        if (push) begin
            mem_d[wr_ptr_q] = cap_sample;
            wr_ptr_d        = wr_ptr_q + 1'b1;
        end

        if (pop) begin
            rd_ptr_d = rd_ptr_q + 1'b1;
        end

        if (push && !pop) begin
            count_d = count_q + 1'b1;
        end else if (!push && pop) begin
            count_d = count_q - 1'b1;
        end

        if (rd_q && !push && (overrun_q != 8'hFF)) begin
            overrun_d = overrun_q + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            rd_q       <= 1'b0;
            ack_meta_q <= 1'b0;
            ack_s_q    <= 1'b0;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            overrun_q  <= '0;
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else begin
            rd_q       <= rd_d;
            ack_meta_q <= ack_meta_d;
            ack_s_q    <= ack_s_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
            overrun_q  <= overrun_d;
            mem_q      <= mem_d;
        end
    end

    // -----------------------------------------------------------------------
    // Handshake FSM. A new sample is only loaded while the synchronised ack
    // is low, so valid can never rise on top of a still-held ack. Data is
    // loaded one cycle before valid rises to give the STM32 a full clock of
    // setup time, and it stays put until the next load in IDLE.
    // WAIT_REL deliberately has no timeout: the STM32 must release ack
    // before the next sample can be offered.
    // -----------------------------------------------------------------------
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q   <= IDLE;
            data_q    <= '0;
            valid_q   <= 1'b0;
            tmo_q     <= '0;
            timeout_q <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (pop) begin
                        data_q  <= mem_q[rd_ptr_q];
                        state_q <= SETUP;
                    end
                end
                SETUP: begin
                    valid_q <= 1'b1;
                    tmo_q   <= '0;
                    state_q <= WAIT_ACK;
                end
                WAIT_ACK: begin
                    if (ack_s_q) begin
                        valid_q <= 1'b0;
                        state_q <= WAIT_REL;
                    end else if (tmo_q == TMO_LAST) begin
                        valid_q <= 1'b0;
                        if (timeout_q != 8'hFF) begin
                            timeout_q <= timeout_q + 1'b1;
                        end
                        state_q <= WAIT_REL;
                    end else begin
                        tmo_q <= tmo_q + 1'b1;
                    end
                end
                WAIT_REL: begin
                    if (!ack_s_q) begin
                        state_q <= IDLE;
                    end
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign read_audio_in       = rd_q;
    assign stm.stm_audio_data  = data_q;
    assign stm.stm_audio_valid = valid_q;
    assign overrun_cnt         = overrun_q;
    assign timeout_cnt         = timeout_q;

endmodule
